// File: rtl/id_fwd_stage_pkg.sv
// id_fwd_stage_pkg: shared defaults for the ID/forwarding front end.
//   FWD_NUM  - default number of forwarding sources (0 = youngest)
//   RS1_LSB  - default bit position of the rs1 field in an instruction
//   RS2_LSB  - default bit position of the rs2 field in an instruction
package id_fwd_stage_pkg;

    localparam int unsigned FWD_NUM   = 3;
    localparam int unsigned RS1_LSB   = 15;
    localparam int unsigned RS2_LSB   = 20;
    localparam int unsigned REG_IDX_W = 5;

endpackage

// File: rtl/id_fwd_stage_mux.sv
// id_fwd_stage_mux: priority select of one operand over NUM_FWD forwarding sources.
// Ports:
//   i_idx       - register index being read
//   i_rf_data   - register-file value for i_idx
//   i_fwd_en    - per-source write enable
//   i_fwd_reg   - per-source destination index, slice k = source k
//   i_fwd_data  - per-source value, slice k = source k
//   i_fwd_rdy   - per-source value valid this cycle
//   o_hit       - some enabled source writes i_idx (never for x0)
//   o_rdy       - selected source has its value (1 when no hit)
//   o_data      - resolved operand value
module id_fwd_mux #(
    parameter int unsigned NUM_FWD   = 3,
    parameter int unsigned REG_IDX_W = 5,
    parameter int unsigned WORD_W    = 32
) (
    input  logic [REG_IDX_W-1:0]         i_idx,
    input  logic [WORD_W-1:0]            i_rf_data,
    input  logic [NUM_FWD-1:0]           i_fwd_en,
    input  logic [NUM_FWD*REG_IDX_W-1:0] i_fwd_reg,
    input  logic [NUM_FWD*WORD_W-1:0]    i_fwd_data,
    input  logic [NUM_FWD-1:0]           i_fwd_rdy,
    output logic                         o_hit,
    output logic                         o_rdy,
    output logic [WORD_W-1:0]            o_data
);

    always_comb begin
        o_hit  = 1'b0;
        o_rdy  = 1'b1;
        o_data = i_rf_data;
        if (i_idx == '0) begin
            o_data = '0;
        end else begin
            // Walk oldest to youngest so the youngest match is the last one written.
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (i_fwd_en[k] && (i_fwd_reg[k*REG_IDX_W +: REG_IDX_W] == i_idx)) begin
                    o_hit  = 1'b1;
                    o_rdy  = i_fwd_rdy[k];
                    o_data = i_fwd_data[k*WORD_W +: WORD_W];
                end
            end
        end
    end

endmodule

// File: rtl/id_fwd_stage.sv
// id_fwd_stage: decode-stage front end between IF and EX.
// Holds the head instruction plus a one-entry skid buffer behind a valid/ready
// handshake, drives register-file read indices and resolves both operands over
// NUM_FWD forwarding sources, stalling while the matched producer is not ready.
// Ports:
//   clk, clr, flush          - clock, sync active-high reset, kill held entries
//   i_valid/o_ready          - upstream handshake (i_pc, i_instr)
//   o_rs1_idx/o_rs2_idx      - register-file read indices (from head)
//   i_rs1_data/i_rs2_data    - register-file read data
//   i_use_rs1/i_use_rs2      - decoder says head reads rs1/rs2
//   i_fwd_en/reg/data/rdy    - forwarding sources, index 0 youngest
//   o_valid/i_ready          - downstream handshake (o_pc, o_instr, operands)
//   o_hazard                 - head waits on an unready producer
//   o_stall_cnt              - saturating count of cycles the head was held
module id_fwd_stage
    import id_fwd_stage_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned INSTR_W   = 32,
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned REG_IDX_W = id_fwd_stage_pkg::REG_IDX_W,
    parameter int unsigned NUM_FWD   = FWD_NUM,
    parameter int unsigned RS1_LSB   = id_fwd_stage_pkg::RS1_LSB,
    parameter int unsigned RS2_LSB   = id_fwd_stage_pkg::RS2_LSB,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         flush,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [ADDR_W-1:0]            i_pc,
    input  logic [INSTR_W-1:0]           i_instr,
    output logic [REG_IDX_W-1:0]         o_rs1_idx,
    output logic [REG_IDX_W-1:0]         o_rs2_idx,
    input  logic [WORD_W-1:0]            i_rs1_data,
    input  logic [WORD_W-1:0]            i_rs2_data,
    input  logic                         i_use_rs1,
    input  logic                         i_use_rs2,
    input  logic [NUM_FWD-1:0]           i_fwd_en,
    input  logic [NUM_FWD*REG_IDX_W-1:0] i_fwd_reg,
    input  logic [NUM_FWD*WORD_W-1:0]    i_fwd_data,
    input  logic [NUM_FWD-1:0]           i_fwd_rdy,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [ADDR_W-1:0]            o_pc,
    output logic [INSTR_W-1:0]           o_instr,
    output logic [WORD_W-1:0]            o_rs1_val,
    output logic [WORD_W-1:0]            o_rs2_val,
    output logic                         o_hazard,
    output logic [CNT_W-1:0]             o_stall_cnt
);

    logic               r_head_valid;
    logic [ADDR_W-1:0]  r_head_pc;
    logic [INSTR_W-1:0] r_head_instr;
    logic               r_skid_valid;
    logic [ADDR_W-1:0]  r_skid_pc;
    logic [INSTR_W-1:0] r_skid_instr;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic w_hit1, w_rdy1, w_hit2, w_rdy2;
    logic w_fire, w_accept;

    assign o_rs1_idx = r_head_instr[RS1_LSB +: REG_IDX_W];
    assign o_rs2_idx = r_head_instr[RS2_LSB +: REG_IDX_W];

    id_fwd_mux #(
        .NUM_FWD   (NUM_FWD),
        .REG_IDX_W (REG_IDX_W),
        .WORD_W    (WORD_W)
    ) u_mux_rs1 (
        .i_idx      (o_rs1_idx),
        .i_rf_data  (i_rs1_data),
        .i_fwd_en   (i_fwd_en),
        .i_fwd_reg  (i_fwd_reg),
        .i_fwd_data (i_fwd_data),
        .i_fwd_rdy  (i_fwd_rdy),
        .o_hit      (w_hit1),
        .o_rdy      (w_rdy1),
        .o_data     (o_rs1_val)
    );

    id_fwd_mux #(
        .NUM_FWD   (NUM_FWD),
        .REG_IDX_W (REG_IDX_W),
        .WORD_W    (WORD_W)
    ) u_mux_rs2 (
        .i_idx      (o_rs2_idx),
        .i_rf_data  (i_rs2_data),
        .i_fwd_en   (i_fwd_en),
        .i_fwd_reg  (i_fwd_reg),
        .i_fwd_data (i_fwd_data),
        .i_fwd_rdy  (i_fwd_rdy),
        .o_hit      (w_hit2),
        .o_rdy      (w_rdy2),
        .o_data     (o_rs2_val)
    );

    assign o_hazard    = r_head_valid &&
                         ((i_use_rs1 && w_hit1 && !w_rdy1) || (i_use_rs2 && w_hit2 && !w_rdy2));
    assign o_valid     = r_head_valid && !o_hazard;
    // Ready depends only on registered state, so i_ready never reaches o_ready.
    assign o_ready     = !r_skid_valid;
    assign w_fire      = o_valid && i_ready;
    assign w_accept    = i_valid && o_ready;
    assign o_pc        = r_head_pc;
    assign o_instr     = r_head_instr;
    assign o_stall_cnt = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_head_valid <= 1'b0;
            r_head_pc    <= '0;
            r_head_instr <= '0;
            r_skid_valid <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (r_head_valid && !w_fire && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (flush) begin
                r_head_valid <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (w_fire && r_skid_valid) begin
                r_head_pc    <= r_skid_pc;
                r_head_instr <= r_skid_instr;
                r_skid_valid <= 1'b0;
            end else if (w_fire) begin
                r_head_pc    <= i_pc;
                r_head_instr <= i_instr;
                r_head_valid <= w_accept;
            end else if (w_accept && r_head_valid) begin
                r_skid_pc    <= i_pc;
                r_skid_instr <= i_instr;
                r_skid_valid <= 1'b1;
            end else if (w_accept) begin
                r_head_pc    <= i_pc;
                r_head_instr <= i_instr;
                r_head_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_id_fwd_stage.sv
module tb_id_fwd_stage;

    localparam int NF = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          clr, flush, i_valid, i_ready, o_ready, o_valid, o_hazard;
    logic [31:0]   i_pc, i_instr, o_pc, o_instr;
    logic [4:0]    o_rs1_idx, o_rs2_idx;
    logic [31:0]   i_rs1_data, i_rs2_data, o_rs1_val, o_rs2_val;
    logic          i_use_rs1, i_use_rs2;
    logic [NF-1:0]    i_fwd_en, i_fwd_rdy;
    logic [NF*5-1:0]  i_fwd_reg;
    logic [NF*32-1:0] i_fwd_data;
    logic [CW-1:0] o_stall_cnt;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   n_issued = 0;

    always #5 clk = ~clk;

    // Register file model: rs1 reads idx*4, rs2 reads idx*4+1.
    assign i_rs1_data = {27'd0, o_rs1_idx} << 2;
    assign i_rs2_data = ({27'd0, o_rs2_idx} << 2) + 32'd1;

    id_fwd_stage #(.CNT_W(CW)) dut (
        .clk         (clk),
        .clr         (clr),
        .flush       (flush),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_pc        (i_pc),
        .i_instr     (i_instr),
        .o_rs1_idx   (o_rs1_idx),
        .o_rs2_idx   (o_rs2_idx),
        .i_rs1_data  (i_rs1_data),
        .i_rs2_data  (i_rs2_data),
        .i_use_rs1   (i_use_rs1),
        .i_use_rs2   (i_use_rs2),
        .i_fwd_en    (i_fwd_en),
        .i_fwd_reg   (i_fwd_reg),
        .i_fwd_data  (i_fwd_data),
        .i_fwd_rdy   (i_fwd_rdy),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_pc        (o_pc),
        .o_instr     (o_instr),
        .o_rs1_val   (o_rs1_val),
        .o_rs2_val   (o_rs2_val),
        .o_hazard    (o_hazard),
        .o_stall_cnt (o_stall_cnt)
    );

    // Scoreboard: every issue must match the oldest expected entry.
    always @(negedge clk) begin
        if (!clr && o_valid && i_ready) begin
            n_issued++;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_issue got pc=%h instr=%h, required no issue", o_pc, o_instr);
            end else begin
                mon_e = q.pop_front();
                if ({o_pc, o_instr, o_rs1_val, o_rs2_val} !== mon_e) begin
                    failures++;
                    $display("FAIL issue got pc=%h instr=%h rs1=%h rs2=%h required pc=%h instr=%h rs1=%h rs2=%h",
                             o_pc, o_instr, o_rs1_val, o_rs2_val,
                             mon_e.pc, mon_e.instr, mon_e.rs1, mon_e.rs2);
                end
            end
        end
    end

    function automatic logic [31:0] mk(input logic [4:0] rs1, input logic [4:0] rs2);
        mk = {7'h0, rs2, rs1, 3'h0, 5'h1, 7'h33};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        // Only used as a formatting shorthand inside each test task.
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got %h required %h", name, got, req);
        end
    endtask

    task automatic idle_inputs();
        flush     = 1'b0;
        i_valid   = 1'b0;
        i_ready   = 1'b1;
        i_pc      = '0;
        i_instr   = '0;
        i_use_rs1 = 1'b1;
        i_use_rs2 = 1'b1;
        i_fwd_en  = '0;
        i_fwd_reg = '0;
        i_fwd_data = '0;
        i_fwd_rdy = '1;
    endtask

    task automatic do_reset();
        idle_inputs();
        clr = 1'b1;
        step();
        step();
        clr = 1'b0;
        q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        if (o_valid !== 1'b0) begin checks++; failures++; $display("FAIL reset_valid got %b required 0", o_valid); end
        else checks++;
        if (o_ready !== 1'b1) begin checks++; failures++; $display("FAIL reset_ready got %b required 1", o_ready); end
        else checks++;
        chk("reset_pc", o_pc, 32'h0);
        chk("reset_instr", o_instr, 32'h0);
        chk("reset_stall_cnt", 32'(o_stall_cnt), 32'h0);
        chk("reset_hazard", 32'(o_hazard), 32'h0);
    endtask

    task automatic test_back_to_back();
        int base;
        do_reset();
        base = n_issued;
        for (int i = 0; i < 4; i++) begin
            i_valid = 1'b1;
            i_pc    = 32'h100 + 32'(i * 4);
            i_instr = mk(5'(i + 1), 5'(i + 2));
            q.push_back({i_pc, i_instr, 32'((i + 1) * 4), 32'((i + 2) * 4 + 1)});
            #1;
            if (i > 0) begin
                chk("b2b_valid", 32'(o_valid), 32'h1);
                chk("b2b_rs1_val", o_rs1_val, 32'(i * 4));
                chk("b2b_ready", 32'(o_ready), 32'h1);
            end
            step();
        end
        i_valid = 1'b0;
        step();
        chk("b2b_issued", 32'(n_issued - base), 32'd4);
        chk("b2b_queue_empty", 32'(q.size()), 32'd0);
        chk("b2b_stall_cnt", 32'(o_stall_cnt), 32'd0);
    endtask

    task automatic test_priority();
        do_reset();
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_pc    = 32'h300;
        i_instr = mk(5'd5, 5'd0);
        step();
        i_valid = 1'b0;
        i_fwd_en = 3'b101;
        i_fwd_reg[0+:5] = 5'd5;
        i_fwd_reg[10+:5] = 5'd5;
        i_fwd_data[0+:32] = 32'hAAAA;
        i_fwd_data[64+:32] = 32'hBBBB;
        i_fwd_rdy = 3'b111;
        #1;
        chk("prio_rs1_idx", 32'(o_rs1_idx), 32'd5);
        chk("prio_src0", o_rs1_val, 32'hAAAA);
        chk("prio_valid", 32'(o_valid), 32'h1);
        i_fwd_en = 3'b100;
        #1;
        chk("prio_src2", o_rs1_val, 32'hBBBB);
        i_fwd_en = 3'b110;
        i_fwd_reg[5+:5] = 5'd5;
        i_fwd_data[32+:32] = 32'hCCCC;
        #1;
        chk("prio_src1_over_src2", o_rs1_val, 32'hCCCC);
        i_fwd_en = 3'b100;
        q.push_back({32'h300, mk(5'd5, 5'd0), 32'hBBBB, 32'h0});
        i_ready = 1'b1;
        step();
        chk("prio_queue_empty", 32'(q.size()), 32'd0);
        idle_inputs();
    endtask

    task automatic test_load_use();
        do_reset();
        i_fwd_en = 3'b001;
        i_fwd_reg[0+:5] = 5'd7;
        i_fwd_data[0+:32] = 32'h1234;
        i_fwd_rdy = 3'b000;
        q.push_back({32'h200, mk(5'd3, 5'd7), 32'd12, 32'h1234});
        q.push_back({32'h204, mk(5'd1, 5'd2), 32'd4, 32'd9});
        i_valid = 1'b1;
        i_pc    = 32'h200;
        i_instr = mk(5'd3, 5'd7);
        step();
        i_pc    = 32'h204;
        i_instr = mk(5'd1, 5'd2);
        #1;
        chk("lu_hazard_c1", 32'(o_hazard), 32'h1);
        chk("lu_valid_c1", 32'(o_valid), 32'h0);
        step();
        i_valid = 1'b0;
        #1;
        chk("lu_hazard_c2", 32'(o_hazard), 32'h1);
        chk("lu_valid_c2", 32'(o_valid), 32'h0);
        chk("lu_skid_ready", 32'(o_ready), 32'h0);
        step();
        i_fwd_rdy = 3'b001;
        #1;
        chk("lu_valid_issue", 32'(o_valid), 32'h1);
        chk("lu_rs2_val", o_rs2_val, 32'h1234);
        chk("lu_stall_cnt", 32'(o_stall_cnt), 32'd2);
        chk("lu_ready_held", 32'(o_ready), 32'h0);
        step();
        chk("lu_next_pc", o_pc, 32'h204);
        chk("lu_ready_drained", 32'(o_ready), 32'h1);
        step();
        chk("lu_queue_empty", 32'(q.size()), 32'd0);
        chk("lu_stall_cnt_end", 32'(o_stall_cnt), 32'd2);
        idle_inputs();
    endtask

    task automatic test_x0_use();
        do_reset();
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_pc    = 32'h400;
        i_instr = mk(5'd0, 5'd9);
        step();
        i_valid = 1'b0;
        i_fwd_en = 3'b001;
        i_fwd_reg[0+:5] = 5'd0;
        i_fwd_data[0+:32] = 32'hDEAD;
        i_fwd_rdy = 3'b000;
        #1;
        chk("x0_rs1_val", o_rs1_val, 32'h0);
        chk("x0_hazard", 32'(o_hazard), 32'h0);
        i_fwd_reg[0+:5] = 5'd9;
        i_use_rs2 = 1'b0;
        #1;
        chk("mask_hazard", 32'(o_hazard), 32'h0);
        chk("mask_rs2_val", o_rs2_val, 32'hDEAD);
        i_use_rs2 = 1'b1;
        #1;
        chk("unmask_hazard", 32'(o_hazard), 32'h1);
        i_use_rs2 = 1'b0;
        q.push_back({32'h400, mk(5'd0, 5'd9), 32'h0, 32'hDEAD});
        i_ready = 1'b1;
        step();
        chk("x0_queue_empty", 32'(q.size()), 32'd0);
        idle_inputs();
    endtask

    task automatic test_flush();
        int base;
        do_reset();
        base = n_issued;
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_pc    = 32'h500;
        i_instr = mk(5'd1, 5'd1);
        step();
        i_pc    = 32'h504;
        i_instr = mk(5'd2, 5'd2);
        step();
        #1;
        chk("fl_ready_full", 32'(o_ready), 32'h0);
        flush   = 1'b1;
        i_pc    = 32'h508;
        i_instr = mk(5'd3, 5'd3);
        step();
        flush   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        #1;
        chk("fl_valid", 32'(o_valid), 32'h0);
        chk("fl_ready", 32'(o_ready), 32'h1);
        // Accept and flush in the same cycle on an empty stage: dropped.
        flush   = 1'b1;
        i_valid = 1'b1;
        i_pc    = 32'h50C;
        step();
        flush   = 1'b0;
        i_valid = 1'b0;
        #1;
        chk("fl_drop_valid", 32'(o_valid), 32'h0);
        step();
        step();
        chk("fl_no_issue", 32'(n_issued - base), 32'd0);
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        i_fwd_en = 3'b001;
        i_fwd_reg[0+:5] = 5'd7;
        i_fwd_rdy = 3'b000;
        i_valid = 1'b1;
        i_pc    = 32'h600;
        i_instr = mk(5'd3, 5'd7);
        step();
        i_pc    = 32'h604;
        step();
        i_valid = 1'b0;
        #1;
        chk("rms_skid_full", 32'(o_ready), 32'h0);
        chk("rms_hazard", 32'(o_hazard), 32'h1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        #1;
        chk("rms_valid", 32'(o_valid), 32'h0);
        chk("rms_pc", o_pc, 32'h0);
        chk("rms_stall_cnt", 32'(o_stall_cnt), 32'h0);
        chk("rms_ready", 32'(o_ready), 32'h1);
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_saturate();
        do_reset();
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_pc    = 32'h700;
        i_instr = mk(5'd1, 5'd2);
        step();
        i_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("sat_mid", 32'(o_stall_cnt), 32'd10);
        for (int i = 0; i < 9; i++) step();
        chk("sat_hold", 32'(o_stall_cnt), 32'd15);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        chk("sat_flush_keeps", 32'(o_stall_cnt), 32'd15);
        chk("sat_flush_valid", 32'(o_valid), 32'h0);
        do_reset();
    endtask

    initial begin
        clr = 1'b1;
        idle_inputs();
        test_reset();
        test_back_to_back();
        test_priority();
        test_load_use();
        test_x0_use();
        test_flush();
        test_reset_mid_stall();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
